// File: rtl/tick_pkg.sv
// Shared constants and helpers for the tick generator: default clock rate,
// counter width derivation and the configuration channel-index width.
package tick_pkg;

    localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;
    localparam int CFG_CH_W            = 4;

    // Bits needed to hold freq_hz itself, since it is loaded as a divisor value.
    function automatic int cnt_width(input int freq_hz);
        return $clog2(freq_hz + 1);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divisor register, free-running counter, registered tick
// pulse and a square wave that toggles on every tick.
module tick_channel #(
    parameter int               CNT_W     = 27,
    parameter logic [CNT_W-1:0] RESET_DIV = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             square
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_div;
    logic             term;

    // Divisors of 0 and 1 both mean "tick every enabled cycle".
    assign eff_div = (div <= CNT_W'(1)) ? CNT_W'(1) : div;
    assign term    = (cnt == eff_div - CNT_W'(1));

    // A load also realigns its own channel, so it covers the load+sync case.
    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= RESET_DIV;
            cnt    <= '0;
            tick   <= 1'b0;
            square <= 1'b0;
        end else if (load) begin
            div  <= load_div;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (sync) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (term) begin
                cnt    <= '0;
                tick   <= 1'b1;
                square <= ~square;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator: N_CH independent programmable dividers sharing
// one enable/sync, with a single divisor-load port decoded by channel index.
module tick_generator
    import tick_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int N_CH        = 4,
    parameter int CNT_W       = cnt_width(DEFAULT_CLK_FREQ_HZ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic                cfg_err,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     square
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("tick_generator: N_CH must be in 1..16");
    end
    if (64'(CLK_FREQ_HZ) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("tick_generator: CLK_FREQ_HZ does not fit in CNT_W bits");
    end

    logic accept;
    logic ch_bad;

    assign cfg_ready = ~rst;
    assign accept    = cfg_valid & cfg_ready;
    assign ch_bad    = (int'(cfg_ch) >= N_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ch_bad;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam logic [CFG_CH_W-1:0] CH_IDX = CFG_CH_W'(c);

        tick_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (CNT_W'(CLK_FREQ_HZ))
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .sync     (sync),
            .load     (accept && (cfg_ch == CH_IDX)),
            .load_div (cfg_div),
            .tick     (tick[c]),
            .square   (square[c])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator at CLK_FREQ_HZ=10, N_CH=2, CNT_W=4.
module tb_tick_generator;

    localparam int CLK_FREQ_HZ = 10;
    localparam int N_CH        = 2;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sync;
    logic             cfg_valid;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  square;

    int checks   = 0;
    int failures = 0;

    tick_generator #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .N_CH        (N_CH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .square    (square)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       sync;
        logic       v;
        logic [3:0] ch;
        logic [3:0] div;
        int         rep;
        logic [1:0] exp_tick;
        logic [1:0] exp_sq;
        logic       exp_err;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic s, input logic v,
                       input logic [3:0] ch, input logic [3:0] dv, input int rep,
                       input logic [1:0] tk, input logic [1:0] sq,
                       input logic er, input logic rd);
        vec_t x;
        x.rst = r; x.en = e; x.sync = s; x.v = v; x.ch = ch; x.div = dv; x.rep = rep;
        x.exp_tick = tk; x.exp_sq = sq; x.exp_err = er; x.exp_rdy = rd;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic edge_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;

        // Sequence A: 40 enabled cycles out of reset, both channels at div 10.
        edge_n(2);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_square", 32'(square), 32'd0);
        chk("reset_ready", 32'(cfg_ready), 32'd0);
        chk("reset_err", 32'(cfg_err), 32'd0);
        rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            edge_n(1);
            chk($sformatf("run40_tick_k%0d", k), 32'(tick), (k % 10 == 0) ? 32'd3 : 32'd0);
            chk($sformatf("run40_sq_k%0d", k), 32'(square), ((k / 10) % 2 == 1) ? 32'd3 : 32'd0);
        end

        //   rst en sy v ch div rep tick   sq    err  rdy
        add(1, 1, 0, 0, 0, 0,  2, 2'b00, 2'b00, 0, 0);
        add(0, 1, 0, 0, 0, 0,  9, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b00, 2'b11, 0, 1);
        add(0, 1, 0, 1, 1, 3,  1, 2'b00, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  2, 2'b00, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b10, 2'b01, 0, 1);
        add(0, 1, 0, 0, 0, 0,  3, 2'b10, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b00, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b10, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b10, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  6, 2'b10, 2'b00, 0, 1);
        add(0, 0, 0, 0, 0, 0,  5, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  2, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b11, 0, 1);
        add(0, 1, 0, 1, 0, 0,  1, 2'b00, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b10, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b01, 0, 1);
        add(0, 1, 0, 1, 0, 1,  1, 2'b00, 2'b01, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b11, 0, 1);
        add(0, 1, 0, 1, 3, 5,  1, 2'b01, 2'b10, 1, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  2, 2'b01, 2'b00, 0, 1);
        add(0, 1, 0, 1, 1, 4,  1, 2'b01, 2'b01, 0, 1);
        add(0, 1, 0, 0, 0, 0,  3, 2'b01, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b11, 0, 1);
        add(0, 1, 0, 1, 0, 10, 1, 2'b00, 2'b11, 0, 1);
        add(0, 1, 0, 0, 0, 0,  5, 2'b00, 2'b01, 0, 1);
        add(0, 1, 1, 0, 0, 0,  1, 2'b00, 2'b01, 0, 1);
        add(0, 1, 0, 0, 0, 0,  9, 2'b00, 2'b01, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b01, 2'b00, 0, 1);
        add(0, 1, 1, 1, 1, 2,  1, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b10, 2'b10, 0, 1);
        add(0, 1, 0, 0, 0, 0,  3, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b10, 2'b10, 0, 1);
        add(1, 1, 0, 1, 3, 5,  1, 2'b00, 2'b00, 0, 0);
        add(0, 1, 0, 0, 0, 0,  9, 2'b00, 2'b00, 0, 1);
        add(0, 1, 0, 0, 0, 0,  1, 2'b11, 2'b11, 0, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; sync = vecs[i].sync;
            cfg_valid = vecs[i].v; cfg_ch = vecs[i].ch; cfg_div = vecs[i].div;
            edge_n(1);
            cfg_valid = 1'b0; sync = 1'b0;
            if (vecs[i].rep > 1) edge_n(vecs[i].rep - 1);
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            chk($sformatf("vec%0d_square", i), 32'(square), 32'(vecs[i].exp_sq));
            chk($sformatf("vec%0d_cfg_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].exp_rdy));
        end

        // Sequence B: load ch1 with div 5, bounded wait for its first tick.
        begin
            int lat;
            lat = -1;
            cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 4'd5;
            edge_n(1);
            cfg_valid = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                edge_n(1);
                if (tick[1] && lat < 0) lat = k;
            end
            if (lat < 0) begin
                checks++;
                failures++;
                $display("FAIL load_latency timeout got=none exp=5");
            end else begin
                chk("load_latency", 32'(lat), 32'd5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, input clock frequency and reset divisor of every channel (1 Hz ticks).
REQ-002 Parameter N_CH, default 4, number of independent tick channels (1..16).
REQ-003 Parameter CNT_W, default 27, divisor/counter width; CLK_FREQ_HZ SHALL fit in CNT_W bits (elaboration-time check).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  global count enable; low freezes all counters.
REQ-007 sync  input  1  one-cycle realign strobe; clears all channel counters.
REQ-008 cfg_valid  input  1  divisor-load request.
REQ-009 cfg_ch  input  4  target channel index.
REQ-010 cfg_div  input  CNT_W  new divisor, in clk cycles per tick.
REQ-011 cfg_ready  output  1  load accepted when cfg_valid && cfg_ready.
REQ-012 cfg_err  output  1  one-cycle pulse: accepted load with cfg_ch >= N_CH.
REQ-013 tick  output  N_CH  per-channel one-cycle pulse, once per divisor period.
REQ-014 square  output  N_CH  per-channel square wave; toggles on each tick, so its period is 2*divisor.

Function
REQ-015 Each channel SHALL hold a divisor register div[c] and a counter cnt[c] of CNT_W bits.
REQ-016 With en=1, cnt[c] == div[c]-1: cnt[c] <= 0, tick[c] <= 1, square[c] toggles; otherwise cnt[c] increments and tick[c] <= 0.
REQ-017 tick is registered: it is high in the cycle after cnt reaches div-1; steady-state tick period is exactly div[c] cycles.
REQ-018 A divisor of 0 or 1 SHALL be treated as 1: tick high every enabled cycle, square toggles every cycle.
REQ-019 With en=0: counters and square hold their values; tick outputs are 0.
REQ-020 sync=1: all cnt <= 0, all tick <= 0, square unchanged; sync overrides en and terminal count in the same cycle.
REQ-021 cfg_ready SHALL be 1 in every cycle except when rst is high.
REQ-022 On an accepted load with cfg_ch < N_CH: div[cfg_ch] <= cfg_div, cnt[cfg_ch] <= 0, and tick[cfg_ch] <= 0 in that cycle, even if the old terminal count coincides (the load wins).
REQ-023 On an accepted load with cfg_ch >= N_CH: no state changes, and cfg_err pulses high for one cycle.
REQ-024 When a load and sync occur in the same cycle, both take effect; the loaded channel ends with the new divisor and a counter of 0.
REQ-025 Channels are independent; a load to one channel SHALL NOT disturb any other channel's count.

Reset
REQ-026 While rst is high: every div[c] <= CLK_FREQ_HZ, cnt <= 0, tick <= 0, square <= 0, cfg_err <= 0, cfg_ready = 0.
REQ-027 Reset asserted mid-period SHALL abort that period; the first tick after release occurs CLK_FREQ_HZ cycles after the first enabled cycle.

Structure
REQ-028 Shared package tick_pkg SHALL hold the default CLK_FREQ_HZ constant, the CNT_W derivation function (clog2-based), and the cfg channel-index width.
REQ-029 One sub-module, tick_channel (single divisor, counter, tick and square), SHALL be instantiated N_CH times by a generate loop.
REQ-030 The top level contains only the cfg decode, cfg_err, and the cfg_ready logic.

Verification (CLK_FREQ_HZ=10, N_CH=2, CNT_W=4)
REQ-031 Release reset with en=1 for 40 cycles -> both ticks pulse every 10 cycles and square toggles at each pulse.
REQ-032 Load ch1 with div=3 in the middle of a period -> ch1 ticks 3 cycles after the load and every 3 cycles after that; ch0 timing is unchanged.
REQ-033 Load div=0, then div=1, on ch0 -> tick[0] is high on every enabled cycle.
REQ-034 Drop en for 5 cycles at cnt=7 -> tick stays 0 and the next tick comes 3 enabled cycles after en returns.
REQ-035 Load to ch=3 -> cfg_err pulses for one cycle and no divisor changes; a load coinciding with terminal count -> no tick in that cycle.
REQ-036 Assert sync and, separately, rst at cnt=5 -> counters restart from 0; after rst, square=0 and div returns to 10.
